// File: rtl/h14tx_period_sched.sv
// h14tx_period_sched: HDMI 1.4 TX period scheduler (video timing plus data-island packing).
// Define H14TX_ISLAND_EN to build the data-island FSM; the default build is DVI-only.

typedef enum logic [2:0] {
    Control            = 3'd0,
    VideoPreamble      = 3'd1,
    VideoGuard         = 3'd2,
    VideoActive        = 3'd3,
    DataIslandPreamble = 3'd4,
    DataIslandGuard    = 3'd5,
    DataIslandActive   = 3'd6
} period_t;

module h14tx_period_sched #(
    parameter int HActive = 1280,
    parameter int HTotal  = 1650,
    parameter int MaxPkts = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        video_line,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    output period_t     period,
    output logic [4:0]  pkt_idx,
    output logic [11:0] x
);

    logic [11:0] x_next;
    logic        line_vid;
    logic        vid_next;
    period_t     video_period;
    period_t     period_next;
    logic [4:0]  idx_next;

    assign x_next   = (x == 12'(HTotal - 1)) ? 12'd0 : x + 12'd1;
    assign vid_next = (x == 12'(HTotal - 11)) ? video_line : line_vid;

    // Period for the next x from video timing alone; an island overrides it.
    always_comb begin
        video_period = Control;
        if (vid_next) begin
            if (x_next >= 12'(HTotal - 10) && x_next <= 12'(HTotal - 3))
                video_period = VideoPreamble;
            else if (x_next >= 12'(HTotal - 2))
                video_period = VideoGuard;
            else if (x_next < 12'(HActive))
                video_period = VideoActive;
        end
    end

`ifdef H14TX_ISLAND_EN
    typedef enum logic [2:0] {Idle, Pre, LGuard, Act, TGuard} island_t;

    island_t    state, state_next;
    logic [2:0] cnt, cnt_next;
    logic [5:0] pkts, pkts_next;
    logic       accept;
    logic       room_start;
    logic       room_chain;

    // Room is counted from the next x up to the video preamble at HTotal-10.
    assign room_start = (x_next >= 12'(HActive + 4)) && (x_next <= 12'(HTotal - 66));
    assign room_chain = (x_next <= 12'(HTotal - 56));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pkts_next  = pkts;
        idx_next   = 5'd0;
        accept     = 1'b0;
        case (state)
            Idle: begin
                if (pkt_valid && room_start) begin
                    accept     = 1'b1;
                    pkts_next  = 6'd1;
                    cnt_next   = 3'd0;
                    state_next = Pre;
                end
            end
            Pre: begin
                if (cnt == 3'd7) begin
                    cnt_next   = 3'd0;
                    state_next = LGuard;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            LGuard: begin
                if (cnt == 3'd1) begin
                    cnt_next   = 3'd0;
                    state_next = Act;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            Act: begin
                if (pkt_idx != 5'd31) begin
                    idx_next = pkt_idx + 5'd1;
                end else if (pkt_valid && (pkts < 6'(MaxPkts)) && room_chain) begin
                    accept    = 1'b1;
                    pkts_next = pkts + 6'd1;
                end else begin
                    state_next = TGuard;
                end
            end
            TGuard: begin
                if (cnt == 3'd1) begin
                    cnt_next   = 3'd0;
                    state_next = Idle;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            default: state_next = Idle;
        endcase
    end

    always_comb begin
        case (state_next)
            Pre:            period_next = DataIslandPreamble;
            LGuard, TGuard: period_next = DataIslandGuard;
            Act:            period_next = DataIslandActive;
            default:        period_next = video_period;
        endcase
    end

    assign pkt_ready = accept & rst_n;

    // Reset drops any island in flight; no trailing guard is emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= Idle;
            cnt   <= 3'd0;
            pkts  <= 6'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            pkts  <= pkts_next;
        end
    end
`else
    logic [6:0] unused_dvi;
    assign unused_dvi  = {pkt_valid, 6'(MaxPkts)};
    assign pkt_ready   = 1'b0;
    assign idx_next    = 5'd0;
    assign period_next = video_period;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= 12'd0;
            line_vid <= 1'b0;
            period   <= Control;
            pkt_idx  <= 5'd0;
        end else begin
            x        <= x_next;
            line_vid <= vid_next;
            period   <= period_next;
            pkt_idx  <= idx_next;
        end
    end

endmodule
